// File: rtl/dff_bist.sv
// -----------------------------------------------------------------------------
// dff_bist
//
// Built-in self-test for a single D flip-flop that has outputs q/qb and an
// active-high reset. The block runs in the same clock domain as the flop under
// test.
//
// Each run has three phases:
//   - Reset phase: the flop's reset is held high while d=1, so the reset must
//     win over d.
//   - Data phase: pseudo-random data from an 8-bit LFSR is driven on d.
//   - Check phase: q/qb are compared two cycles later against an internal
//     expected-value pipeline. Mismatches are counted, saturating.
//
// Parameters
//   NUM_VECTORS : random data vectors driven per run (1..255)
//   LFSR_SEED   : LFSR load value at start (0 is replaced by 8'h01)
//   ERR_W       : width of the error counter
//
// Ports
//   clk     in   clock, everything is posedge
//   rst     in   asynchronous active-low reset of this block
//   start   in   one-cycle run request, sampled only in IDLE or DONE
//   dut_rst out  active-high reset to the flop under test
//   dut_d   out  data to the flop under test
//   dut_q   in   flop output
//   dut_qb  in   flop complement output
//   busy    out  high while a run is in progress (RESET, RUN, DRAIN)
//   done    out  high in DONE until the next accepted start or rst
//   pass    out  done && err_cnt == 0
//   err_cnt out  mismatch count, saturating at all-ones
// -----------------------------------------------------------------------------
module dff_bist #(
  parameter int         NUM_VECTORS = 10,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  parameter int         ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_rst,
  output logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
  localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]       LAST_VEC = 8'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state, state_next;
  logic [7:0]       cnt, cnt_next;
  logic [7:0]       lfsr, lfsr_next;
  logic             dut_rst_next, dut_d_next;
  logic             busy_next, done_next, pass_next;
  logic [ERR_W-1:0] err_next;

  // Two-stage expected-value pipeline. Stage 2 lines up with the flop output
  // that results from what was driven two edges earlier.
  logic s1_valid, s1_exp, s2_valid, s2_exp;
  logic push_valid, push_exp;
  logic mismatch;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // A single check counts at most one error, whether q, qb or both are wrong.
  assign mismatch = s2_valid && ((dut_q != s2_exp) || (dut_qb != ~s2_exp));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next   = state;
    cnt_next     = cnt;
    lfsr_next    = lfsr;
    dut_rst_next = dut_rst;
    dut_d_next   = dut_d;
    done_next    = done;
    err_next     = err_cnt;

    if (mismatch && (err_cnt != ERR_MAX)) begin
      err_next = err_cnt + ERR_W'(1);
    end

    unique case (state)
      S_IDLE, S_DONE: begin
        dut_rst_next = 1'b1;
        dut_d_next   = 1'b0;
        if (start) begin
          state_next   = S_RESET;
          cnt_next     = '0;
          lfsr_next    = SEED;
          err_next     = '0;
          done_next    = 1'b0;
          dut_d_next   = 1'b1;  // the flop's reset must dominate d=1
        end
      end

      S_RESET: begin
        if (cnt == 8'd1) begin
          state_next   = S_RUN;
          cnt_next     = '0;
          dut_rst_next = 1'b0;
          dut_d_next   = lfsr[0];
          lfsr_next    = lfsr_step(lfsr);
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end

      S_RUN: begin
        if (cnt == LAST_VEC) begin
          // dut_d holds its last vector through DRAIN.
          state_next = S_DRAIN;
        end else begin
          cnt_next   = cnt + 8'd1;
          dut_d_next = lfsr[0];
          lfsr_next  = lfsr_step(lfsr);
        end
      end

      S_DRAIN: begin
        state_next   = S_DONE;
        dut_rst_next = 1'b1;
        dut_d_next   = 1'b0;
        done_next    = 1'b1;
      end

      default: state_next = S_IDLE;
    endcase

    busy_next  = (state_next == S_RESET) || (state_next == S_RUN) ||
                 (state_next == S_DRAIN);
    pass_next  = done_next && (err_next == '0);

    // Expected flop content after this edge, from what is driven next.
    push_valid = (state_next == S_RESET) || (state_next == S_RUN);
    push_exp   = dut_rst_next ? 1'b0 : dut_d_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the pipeline is only four flops and must not carry stale valid
    // entries out of an aborted run, so it is reset along with everything else.
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lfsr     <= SEED;
      dut_rst  <= 1'b1;
      dut_d    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_exp   <= 1'b0;
      s2_valid <= 1'b0;
      s2_exp   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from
      // pre-edge values regardless of statement order.
      state    <= state_next;
      cnt      <= cnt_next;
      lfsr     <= lfsr_next;
      dut_rst  <= dut_rst_next;
      dut_d    <= dut_d_next;
      busy     <= busy_next;
      done     <= done_next;
      pass     <= pass_next;
      err_cnt  <= err_next;
      s1_valid <= push_valid;
      s1_exp   <= push_exp;
      s2_valid <= s1_valid;
      s2_exp   <= s1_exp;
    end
  end

endmodule
